// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - per-class round-robin arbiter for scalar/FP/vector writeback ports
module wb_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [2*NUM_REQ-1:0]      i_req_class,
    input  logic [5*NUM_REQ-1:0]      i_req_rd,
    input  logic [DATA_W*NUM_REQ-1:0] i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic                      o_wb_scalar_valid,
    output logic [4:0]                o_wb_scalar_rd,
    output logic [DATA_W-1:0]         o_wb_scalar_data,
    output logic                      o_wb_fp_valid,
    output logic [4:0]                o_wb_fp_rd,
    output logic [DATA_W-1:0]         o_wb_fp_data,
    output logic                      o_wb_vec_valid,
    output logic [4:0]                o_wb_vec_rd,
    output logic [DATA_W-1:0]         o_wb_vec_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NCLS  = 3;

    logic [1:0]         w_cls      [NUM_REQ];
    logic [NUM_REQ-1:0] w_cls_mask [NCLS];
    logic [NCLS-1:0]    w_found;
    logic [PTR_W-1:0]   w_win      [NCLS];
    logic [4:0]         w_win_rd   [NCLS];
    logic [DATA_W-1:0]  w_win_data [NCLS];
    logic [NCLS-1:0]    w_take;
    logic [NUM_REQ-1:0] w_ready;

    logic [PTR_W-1:0]   r_ptr     [NCLS];
    logic [NCLS-1:0]    r_wb_valid;
    logic [4:0]         r_wb_rd   [NCLS];
    logic [DATA_W-1:0]  r_wb_data [NCLS];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (int'(p) == NUM_REQ - 1)
            return '0;
        return p + 1'b1;
    endfunction

    // Class code 11 folds onto the vector port.
    always_comb begin
        for (int c = 0; c < NCLS; c++)
            w_cls_mask[c] = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cls[i] = (i_req_class[2*i +: 2] == 2'b11) ? 2'd2 : i_req_class[2*i +: 2];
            for (int c = 0; c < NCLS; c++)
                w_cls_mask[c][i] = i_req_valid[i] && (w_cls[i] == 2'(c));
        end
    end

    always_comb begin
        for (int c = 0; c < NCLS; c++) begin
            w_found[c] = 1'b0;
            w_win[c]   = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (int'(r_ptr[c]) + k) % NUM_REQ;
                if (!w_found[c] && w_cls_mask[c][idx]) begin
                    w_found[c] = 1'b1;
                    w_win[c]   = PTR_W'(idx);
                end
            end
        end
    end

    // The scalar port swallows writes to x0 while still consuming the grant.
    always_comb begin
        for (int c = 0; c < NCLS; c++) begin
            w_win_rd[c]   = i_req_rd[5*int'(w_win[c]) +: 5];
            w_win_data[c] = i_req_data[DATA_W*int'(w_win[c]) +: DATA_W];
            w_take[c]     = w_found[c] && ((c != 0) || (w_win_rd[c] != 5'd0));
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int c = 0; c < NCLS; c++)
                if (w_found[c] && (int'(w_win[c]) == i))
                    w_ready[i] = 1'b1;
    end

    assign o_req_ready = i_rst ? '0 : w_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < NCLS; c++) begin
                r_ptr[c]     <= '0;
                r_wb_rd[c]   <= '0;
                r_wb_data[c] <= '0;
            end
            r_wb_valid <= '0;
        end else begin
            for (int c = 0; c < NCLS; c++) begin
                r_wb_valid[c] <= w_take[c];
                if (w_found[c])
                    r_ptr[c] <= ptr_inc(w_win[c]);
                if (w_take[c]) begin
                    r_wb_rd[c]   <= w_win_rd[c];
                    r_wb_data[c] <= w_win_data[c];
                end
            end
        end
    end

    assign o_wb_scalar_valid = r_wb_valid[0];
    assign o_wb_scalar_rd    = r_wb_rd[0];
    assign o_wb_scalar_data  = r_wb_data[0];
    assign o_wb_fp_valid     = r_wb_valid[1];
    assign o_wb_fp_rd        = r_wb_rd[1];
    assign o_wb_fp_data      = r_wb_data[1];
    assign o_wb_vec_valid    = r_wb_valid[2];
    assign o_wb_vec_rd       = r_wb_rd[2];
    assign o_wb_vec_data     = r_wb_data[2];

    genvar g;
    for (g = 0; g < NUM_REQ; g++) begin : g_req_chk
        a_ready_implies_valid: assert property (@(posedge i_clk) disable iff (i_rst)
            o_req_ready[g] |-> i_req_valid[g]);
        a_held_stable: assert property (@(posedge i_clk) disable iff (i_rst)
            (i_req_valid[g] && !o_req_ready[g]) |=>
            (!i_req_valid[g] || ($stable(i_req_rd[5*g +: 5]) &&
                                 $stable(i_req_data[DATA_W*g +: DATA_W]))));
    end
    for (g = 0; g < NCLS; g++) begin : g_cls_chk
        a_one_grant_per_class: assert property (@(posedge i_clk) disable iff (i_rst)
            $onehot0(o_req_ready & w_cls_mask[g]));
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   valid;
    logic [7:0]   cls;
    logic [19:0]  rd;
    logic [127:0] data;
    logic [3:0]   ready;
    logic         s_v, f_v, v_v;
    logic [4:0]   s_rd, f_rd, v_rd;
    logic [31:0]  s_d, f_d, v_d;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (valid),
        .i_req_class      (cls),
        .i_req_rd         (rd),
        .i_req_data       (data),
        .o_req_ready      (ready),
        .o_wb_scalar_valid(s_v),
        .o_wb_scalar_rd   (s_rd),
        .o_wb_scalar_data (s_d),
        .o_wb_fp_valid    (f_v),
        .o_wb_fp_rd       (f_rd),
        .o_wb_fp_data     (f_d),
        .o_wb_vec_valid   (v_v),
        .o_wb_vec_rd      (v_rd),
        .o_wb_vec_data    (v_d)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] c,
                           input logic [4:0] r, input logic [31:0] d);
        valid[i]        = v;
        cls[2*i +: 2]   = c;
        rd[5*i +: 5]    = r;
        data[32*i +: 32] = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        valid = '0;
        cls   = '0;
        rd    = '0;
        data  = '0;
        for (int i = 0; i < 4; i++)
            set_req(i, 1'b1, 2'b00, 5'(i + 1), 32'hA000_0000 + 32'(i));
        #3;
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_s_v", 64'(s_v), 64'h0);
        chk("rst_f_v", 64'(f_v), 64'h0);
        chk("rst_v_v", 64'(v_v), 64'h0);
        chk("rst_s_rd", 64'(s_rd), 64'h0);
        chk("rst_s_d", 64'(s_d), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t1_first", 64'(ready), 64'h1);
        step;
        chk("t1_wb_v", 64'(s_v), 64'h1);
        chk("t1_wb_rd", 64'(s_rd), 64'h1);
        set_req(0, 1'b0, 2'b00, 5'd1, 32'hA000_0000);
        #1;
        chk("t1_next", 64'(ready), 64'h2);
        step;
        chk("t1_pre_rst_v", 64'(s_v), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("t1_midrst_s_v", 64'(s_v), 64'h0);
        chk("t1_midrst_s_rd", 64'(s_rd), 64'h0);
        chk("t1_midrst_ready", 64'(ready), 64'h0);
        step;
        step;
        rst = 1'b0;
        set_req(0, 1'b1, 2'b00, 5'd1, 32'hA000_0000);
        #1;

        // round robin over four held scalar requesters
        for (int n = 0; n < 5; n++) begin
            chk("t3_ready", 64'(ready), 64'(4'b0001 << (n % 4)));
            step;
            chk("t3_wb_v", 64'(s_v), 64'h1);
            chk("t3_wb_rd", 64'(s_rd), 64'((n % 4) + 1));
        end
        chk("t3_wb_d", 64'(s_d), 64'hA000_0000);
        valid = '0;
        step;
        chk("t3_idle_v", 64'(s_v), 64'h0);
        chk("t3_idle_rd", 64'(s_rd), 64'h1);

        set_req(1, 1'b1, 2'b00, 5'd5, 32'hDEAD_BEEF);
        #1;
        chk("t2_ready", 64'(ready), 64'h2);
        step;
        chk("t2_v", 64'(s_v), 64'h1);
        chk("t2_rd", 64'(s_rd), 64'h5);
        chk("t2_d", 64'(s_d), 64'hDEAD_BEEF);
        valid = '0;
        step;
        chk("t2_v_once", 64'(s_v), 64'h0);

        set_req(0, 1'b1, 2'b00, 5'd7, 32'h1111_1111);
        set_req(1, 1'b1, 2'b01, 5'd8, 32'h2222_2222);
        set_req(2, 1'b1, 2'b11, 5'd9, 32'h3333_3333);
        #1;
        chk("t4_ready", 64'(ready), 64'h7);
        step;
        chk("t4_s_v", 64'(s_v), 64'h1);
        chk("t4_s_rd", 64'(s_rd), 64'h7);
        chk("t4_f_v", 64'(f_v), 64'h1);
        chk("t4_f_rd", 64'(f_rd), 64'h8);
        chk("t4_f_d", 64'(f_d), 64'h2222_2222);
        chk("t4_v_v", 64'(v_v), 64'h1);
        chk("t4_v_rd", 64'(v_rd), 64'h9);
        chk("t4_v_d", 64'(v_d), 64'h3333_3333);
        valid = '0;
        step;
        chk("t4_idle", 64'({s_v, f_v, v_v}), 64'h0);

        set_req(2, 1'b1, 2'b00, 5'd0, 32'h5555_5555);
        #1;
        chk("t5_ready", 64'(ready), 64'h4);
        step;
        chk("t5_drop_v", 64'(s_v), 64'h0);
        valid = '0;
        set_req(0, 1'b1, 2'b00, 5'd10, 32'h0000_000A);
        set_req(3, 1'b1, 2'b00, 5'd11, 32'h0000_000B);
        #1;
        chk("t5_ptr3", 64'(ready), 64'h8);
        step;
        chk("t5_rd", 64'(s_rd), 64'd11);
        valid = '0;
        step;

        set_req(3, 1'b1, 2'b01, 5'd12, 32'h6666_6666);
        #1;
        chk("t6_r3", 64'(ready), 64'h8);
        step;
        chk("t6_f_v", 64'(f_v), 64'h1);
        chk("t6_f_rd3", 64'(f_rd), 64'd12);
        set_req(0, 1'b1, 2'b01, 5'd13, 32'h7777_7777);
        set_req(3, 1'b1, 2'b01, 5'd14, 32'h8888_8888);
        #1;
        chk("t6_late_r0", 64'(ready), 64'h1);
        step;
        chk("t6_f_rd0", 64'(f_rd), 64'd13);
        set_req(0, 1'b0, 2'b01, 5'd13, 32'h7777_7777);
        #1;
        chk("t6_r3_again", 64'(ready), 64'h8);
        step;
        chk("t6_f_rd3b", 64'(f_rd), 64'd14);
        chk("t6_f_d3b", 64'(f_d), 64'h8888_8888);
        valid = '0;

        set_req(1, 1'b1, 2'b10, 5'd15, 32'h9999_9999);
        #1;
        chk("vec10_ready", 64'(ready), 64'h2);
        step;
        chk("vec10_rd", 64'(v_rd), 64'd15);
        chk("f_idle", 64'(f_v), 64'h0);
        valid = '0;
        step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
